// File: rtl/ram_arb.sv
// Round-robin arbiter giving write-back bursts, single reads and single load writes access to one single-port RAM.
// A grant begins one cycle after it is decided. Back-to-back grants leave no idle cycle, and a WB burst cannot be preempted.
module ram_arb #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WB_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_gnt_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_gnt_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] LD   = 2'd3;

  localparam logic [3:0] LAST_BEAT = 4'(WB_BURST - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [3:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ldat_q, ldat_d;
  logic              rd_valid_q;

  logic       wb_m, rd_m, ld_m;
  logic       final_beat, decide;
  logic [1:0] win;

  always_comb begin
    // A requester finishing its grant this cycle does not take part in this decision.
    wb_m = wb_req_i && (state_q != WB);
    rd_m = rd_req_i && (state_q != RD);
    ld_m = ld_req_i && (state_q != LD);

    final_beat = (state_q == RD) || (state_q == LD) ||
                 ((state_q == WB) && (beat_q == LAST_BEAT));
    decide = (state_q == IDLE) || final_beat;

    win = IDLE;
    case (last_q)
      WB: begin
        if (rd_m)      win = RD;
        else if (ld_m) win = LD;
        else if (wb_m) win = WB;
      end
      RD: begin
        if (ld_m)      win = LD;
        else if (wb_m) win = WB;
        else if (rd_m) win = RD;
      end
      default: begin
        if (wb_m)      win = WB;
        else if (rd_m) win = RD;
        else if (ld_m) win = LD;
      end
    endcase

    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    ldat_d  = ldat_q;

    if (state_q == WB) beat_d = beat_q + 4'd1;

    if (decide) begin
      state_d = win;
      beat_d  = '0;
      if (win != IDLE) last_d = win;
      case (win)
        WB:      addr_d = wb_addr_i;
        RD:      addr_d = rd_addr_i;
        LD: begin
          addr_d = ld_addr_i;
          ldat_d = ld_data_i;
        end
        default: addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= LD;
      beat_q     <= '0;
      addr_q     <= '0;
      ldat_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      ldat_q     <= ldat_d;
      rd_valid_q <= (state_q == RD);
    end
  end

  assign wb_gnt_o   = (state_q == WB);
  assign rd_gnt_o   = (state_q == RD);
  assign ld_gnt_o   = (state_q == LD);
  assign busy_o     = (state_q != IDLE);
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_valid_q ? ram_rdata_i : '0;

  always_comb begin
    ram_cs_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      WB: begin
        ram_cs_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = addr_q + ADDR_W'(beat_q);
        ram_wdata_o = wb_data_i;
      end
      RD: begin
        ram_cs_o    = 1'b1;
        ram_addr_o  = addr_q;
      end
      LD: begin
        ram_cs_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = addr_q;
        ram_wdata_o = ldat_q;
      end
      default: ram_cs_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: a queue of expected grant beats and read returns, drained by a monitor on the falling edge.
module tb_ram_arb;

  typedef struct packed {
    logic [2:0]  g;      // {wb, rd, ld}
    logic        cs;
    logic        we;
    logic        busy;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req, rd_req, ld_req;
  logic [7:0]  wb_addr, rd_addr, ld_addr;
  logic [31:0] wb_data, ld_data;
  logic        wb_gnt, rd_gnt, ld_gnt, rd_valid, busy;
  logic [31:0] rd_data;
  logic        ram_cs, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  exp_t        gq[$];
  logic [31:0] rq[$];
  logic [31:0] wbd[4];
  logic [1:0]  tb_beat;
  logic        prev_rd_gnt = 1'b0;

  logic [31:0] mem[256];
  bit          written[256];

  always #5 clk = ~clk;

  ram_arb #(.ADDR_W(8), .DATA_W(32), .WB_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .wb_req_i(wb_req), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_gnt_o(wb_gnt),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_gnt_o(ld_gnt),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  // Write-back source: presents the table word for the current beat.
  always @(posedge clk or negedge rst) begin
    if (!rst)        tb_beat <= 2'd0;
    else if (wb_gnt) tb_beat <= tb_beat + 2'd1;
    else             tb_beat <= 2'd0;
  end
  assign wb_data = wb_gnt ? wbd[tb_beat] : 32'h0;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h22:   return 32'hCAFE0001;
      8'h80:   return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    if (ram_cs && !ram_we)
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] g, input logic we, input logic [7:0] a,
                              input logic [31:0] d);
    exp_t e;
    e.g = g; e.cs = 1'b1; e.we = we; e.busy = 1'b1; e.addr = a; e.wdata = d;
    return e;
  endfunction

  task automatic push_wb(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
    gq.push_back(mk(3'b100, 1'b1, a0, wbd[0]));
    gq.push_back(mk(3'b100, 1'b1, a1, wbd[1]));
    gq.push_back(mk(3'b100, 1'b1, a2, wbd[2]));
    gq.push_back(mk(3'b100, 1'b1, a3, wbd[3]));
  endtask

  task automatic set_wbd(input logic [31:0] base);
    for (int k = 0; k < 4; k++) wbd[k] = base + 32'(k);
  endtask

  // Monitor: every cycle with an active grant consumes one expected beat.
  always @(negedge clk) begin
    exp_t act;
    act.g = {wb_gnt, rd_gnt, ld_gnt};
    act.cs = ram_cs; act.we = ram_we; act.busy = busy;
    act.addr = ram_addr; act.wdata = ram_wdata;
    if (act.g != 3'b000 || act.cs || act.busy) begin
      if (gq.size() == 0) check("grant_unexpected", 64'(act), 64'(0));
      else                check("grant_beat", 64'(act), 64'(gq.pop_front()));
    end else begin
      check("idle_outputs", 64'(act), 64'(0));
    end
    check("rd_valid_timing", 64'(rd_valid), 64'(prev_rd_gnt));
    if (rd_valid) begin
      if (rq.size() == 0) check("rd_valid_unexpected", 64'(rd_data), 64'hDEAD_0000_0000);
      else                check("rd_data", 64'(rd_data), 64'(rq.pop_front()));
    end else begin
      check("rd_data_idle", 64'(rd_data), 64'(0));
    end
    prev_rd_gnt = rst ? rd_gnt : 1'b0;
  end

  task automatic wait_wb_gnt(output int lat);
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (wb_gnt) begin
        lat = n;
        break;
      end
    end
    wb_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || rd_valid || gq.size() != 0 || rq.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 30), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int lat;
    int c, first_wb, rd_cyc, ld_cyc, ng;
    rst = 1'b0;
    wb_req = 1'b0; rd_req = 1'b0; ld_req = 1'b0;
    wb_addr = 8'h0; rd_addr = 8'h0; ld_addr = 8'h0; ld_data = 32'h0;
    set_wbd(32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({wb_gnt, rd_gnt, ld_gnt, busy, rd_valid, ram_cs, ram_we}), 64'(0));
    check("reset_ram", 64'({ram_addr, ram_wdata}), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single burst from idle at 0x10
    set_wbd(32'hD0D0_0000);
    push_wb(8'h10, 8'h11, 8'h12, 8'h13);
    #1 wb_req = 1'b1; wb_addr = 8'h10;
    wait_wb_gnt(lat);
    check("wb_latency", 64'(lat), 64'(2));
    wait_idle("drain_wb_10");

    // Burst crossing the top of the address space
    set_wbd(32'hE0E0_0000);
    push_wb(8'hFE, 8'hFF, 8'h00, 8'h01);
    @(posedge clk) #1 wb_req = 1'b1; wb_addr = 8'hFE;
    wait_wb_gnt(lat);
    check("wb_wrap_latency", 64'(lat), 64'(2));
    wait_idle("drain_wb_fe");

    // Single read
    gq.push_back(mk(3'b010, 1'b0, 8'h22, 32'h0));
    rq.push_back(32'hCAFE0001);
    @(posedge clk) #1 rd_req = 1'b1; rd_addr = 8'h22;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rd_gnt) begin
        lat = n;
        break;
      end
    end
    rd_req = 1'b0;
    check("rd_latency", 64'(lat), 64'(2));
    wait_idle("drain_rd");

    // All three from reset: wb x4, rd, ld with no bubble
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    set_wbd(32'hF0F0_0000);
    push_wb(8'h40, 8'h41, 8'h42, 8'h43);
    gq.push_back(mk(3'b010, 1'b0, 8'h80, 32'h0));
    gq.push_back(mk(3'b001, 1'b1, 8'h81, 32'h55AA55AA));
    rq.push_back(32'h12345678);
    @(posedge clk) #1;
    wb_req = 1'b1; wb_addr = 8'h40;
    rd_req = 1'b1; rd_addr = 8'h80;
    ld_req = 1'b1; ld_addr = 8'h81; ld_data = 32'h55AA55AA;
    first_wb = -100; rd_cyc = -200; ld_cyc = -300;
    c = 0;
    while ((wb_req || rd_req || ld_req) && c < 20) begin
      @(negedge clk);
      c++;
      if (wb_gnt && first_wb < 0) first_wb = c;
      if (wb_gnt) wb_req = 1'b0;
      if (rd_gnt) begin rd_cyc = c; rd_req = 1'b0; end
      if (ld_gnt) begin ld_cyc = c; ld_req = 1'b0; end
    end
    wb_req = 1'b0; rd_req = 1'b0; ld_req = 1'b0;
    check("rd_follows_burst", 64'(rd_cyc - first_wb), 64'(4));
    check("ld_follows_rd", 64'(ld_cyc - rd_cyc), 64'(1));
    wait_idle("drain_all3");

    // rd and ld held together alternate
    gq.push_back(mk(3'b010, 1'b0, 8'h80, 32'h0));
    gq.push_back(mk(3'b001, 1'b1, 8'h82, 32'h0BADF00D));
    gq.push_back(mk(3'b010, 1'b0, 8'h80, 32'h0));
    gq.push_back(mk(3'b001, 1'b1, 8'h82, 32'h0BADF00D));
    rq.push_back(32'h12345678);
    rq.push_back(32'h12345678);
    @(posedge clk) #1;
    rd_req = 1'b1; rd_addr = 8'h80;
    ld_req = 1'b1; ld_addr = 8'h82; ld_data = 32'h0BADF00D;
    ng = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rd_gnt || ld_gnt) ng++;
      if (ng == 4) break;
    end
    rd_req = 1'b0; ld_req = 1'b0;
    check("alternate_count", 64'(ng), 64'(4));
    wait_idle("drain_alt");

    // Read request withdrawn during a burst never reaches the RAM
    set_wbd(32'hA0A0_0000);
    push_wb(8'h30, 8'h31, 8'h32, 8'h33);
    @(posedge clk) #1 wb_req = 1'b1; wb_addr = 8'h30;
    wait_wb_gnt(lat);
    @(posedge clk) #1 rd_req = 1'b1; rd_addr = 8'h99;
    @(posedge clk) #1 rd_req = 1'b0;
    wait_idle("drain_dropped_rd");

    // Reset during the second beat aborts the burst
    set_wbd(32'hB0B0_0000);
    gq.push_back(mk(3'b100, 1'b1, 8'h50, wbd[0]));
    gq.push_back(mk(3'b100, 1'b1, 8'h51, wbd[1]));
    @(posedge clk) #1 wb_req = 1'b1; wb_addr = 8'h50;
    wait_wb_gnt(lat);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ctrl", 64'({wb_gnt, rd_gnt, ld_gnt, busy, ram_cs, ram_we, rd_valid}), 64'(0));
    check("abort_ram", 64'({ram_addr, ram_wdata}), 64'(0));
    @(negedge clk) rst = 1'b1;
    repeat (6) @(negedge clk);

    check("queues_drained", 64'(gq.size() + rq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter: ADDR_W, 8, RAM address width.
REQ-002 Parameter: DATA_W, 32, RAM data width.
REQ-003 Parameter: WB_BURST, 4, beats per write-back burst (range 1..16).
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 wb_req  in  1  write-back burst request, held until first wb_gnt.
REQ-007 wb_addr  in  ADDR_W  burst base address, valid while wb_req high.
REQ-008 wb_data  in  DATA_W  write data for the current beat.
REQ-009 wb_gnt  out  1  high on every granted write-back beat.
REQ-010 rd_req / rd_addr  in  1 / ADDR_W  single-beat read request and address.
REQ-011 rd_gnt  out  1  high on the read access cycle.
REQ-012 rd_valid / rd_data  out  1 / DATA_W  read return strobe and data.
REQ-013 ld_req / ld_addr / ld_data  in  1 / ADDR_W / DATA_W  single-beat load write request.
REQ-014 ld_gnt  out  1  high on the load access cycle.
REQ-015 ram_cs / ram_we  out  1 / 1  single-port RAM select and write enable.
REQ-016 ram_addr / ram_wdata  out  ADDR_W / DATA_W  RAM address and write data.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read access.
REQ-018 busy  out  1  high while any grant is active.

Function
REQ-019 Arbiter SHALL use states IDLE, WB, RD, LD; at most one of wb_gnt/rd_gnt/ld_gnt high per cycle.
REQ-020 Arbitration SHALL happen in IDLE, or in the final beat of any grant; the winner's gnt rises the next cycle, so IDLE with req -> gnt latency is 1 cycle and back-to-back grants have no bubble.
REQ-021 Priority SHALL be round-robin in order wb -> rd -> ld -> wb; the requester served most recently is lowest priority.
REQ-022 The requester in its final beat SHALL be masked from the decision made in that beat.
REQ-023 A WB grant SHALL last exactly WB_BURST consecutive cycles and SHALL NOT be preempted; wb_req is ignored once the burst starts.
REQ-024 wb_addr SHALL be captured when WB is won; beat k drives ram_addr = base + k, modulo 2^ADDR_W (wrap 255 -> 0).
REQ-025 RD and LD grants SHALL last exactly one cycle.
REQ-026 During a grant cycle ram_cs = 1, ram_we = 1 for WB/LD and 0 for RD, and ram_wdata = the granted requester's data (0 for RD).
REQ-027 During a grant cycle ram_addr = the granted requester's address (burst address for WB).
REQ-028 With no grant active, ram_cs, ram_we, ram_addr and ram_wdata SHALL be 0.
REQ-029 rd_valid SHALL be high exactly one cycle after each rd_gnt cycle.
REQ-030 rd_data SHALL equal ram_rdata when rd_valid = 1 and 0 otherwise.
REQ-031 busy SHALL equal wb_gnt | rd_gnt | ld_gnt.
REQ-032 With all requests simultaneous from IDLE after reset, the grant order SHALL be wb, rd, ld.
REQ-033 A request deasserted before its grant SHALL be dropped without a RAM access.

Reset
REQ-034 On rst low, asynchronously: state IDLE; all gnt, rd_valid, busy and RAM outputs 0; rd_data 0; beat counter 0; round-robin pointer set so wb has highest priority.
REQ-035 Reset mid-burst SHALL abort the burst with no further RAM access; after release the arbiter starts in IDLE.

Verification
REQ-036 Idle wb_req, wb_addr = 0x10, data D0..D3 -> wb_gnt 4 cycles, ram_we = 1, ram_addr 0x10..0x13, ram_wdata D0..D3, then IDLE.
REQ-037 wb_addr = 0xFE burst -> ram_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-038 wb, rd, ld requested together from reset -> 4 wb beats, then rd_gnt, then ld_gnt, each back-to-back, no idle cycle.
REQ-039 rd_req, rd_addr = 0x22, RAM returns 0xCAFE0001 -> rd_gnt 1 cycle with ram_we = 0, rd_valid next cycle, rd_data = 0xCAFE0001.
REQ-040 rd_req and ld_req held continuously -> grants alternate rd, ld, rd, ld.
REQ-041 rst low during beat 2 of a burst -> all outputs 0 immediately; after release no access until a new request.
